// File: rtl/ps2_ascii_fsm.sv
// PS/2 keyboard receiver with scan-code-set-2 to ASCII (US layout) decoder.
// Synchronizes the PS/2 lines, assembles 11-bit frames, tracks make/break,
// extended prefix, Shift and CapsLock, and presents the held key as ASCII.
// Optional feature macro: PS2_PARITY_CHECK_EN (drop frames with bad parity/stop).
module ps2_ascii_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       data,
  output logic [7:0] asc,
  output logic       en
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t state, state_next;
  logic [2:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, bit_in, timeout, frame_ok;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, byte_reg;
  logic          byte_valid;
  logic          ext_flag, brk_flag, shift_on, caps_on, held;
  logic [7:0]    held_code;

  assign fall    = clk_prev & ~clk_sync[2];
  assign bit_in  = dat_sync[2];
  assign timeout = (state != S_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign en      = held;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign frame_ok = bit_in & (^{shreg, par_bit});
  // Parity bit capture, only needed when frames are validated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_bit <= 1'b0;
    else if (fall && state == S_PARITY) par_bit <= bit_in;
  end
`else
  assign frame_ok = 1'b1;
`endif

  // Scan code to ASCII; letters follow Shift XOR Caps, everything else Shift only
  function automatic logic [7:0] map_code(input logic [7:0] c, input logic sh, input logic cp);
    logic [7:0] lo, hi;
    logic       letter;
    lo = '0; hi = '0; letter = 1'b0;
    case (c)
      8'h1C: begin lo = 8'h61; letter = 1'b1; end
      8'h32: begin lo = 8'h62; letter = 1'b1; end
      8'h21: begin lo = 8'h63; letter = 1'b1; end
      8'h23: begin lo = 8'h64; letter = 1'b1; end
      8'h24: begin lo = 8'h65; letter = 1'b1; end
      8'h2B: begin lo = 8'h66; letter = 1'b1; end
      8'h34: begin lo = 8'h67; letter = 1'b1; end
      8'h33: begin lo = 8'h68; letter = 1'b1; end
      8'h43: begin lo = 8'h69; letter = 1'b1; end
      8'h3B: begin lo = 8'h6A; letter = 1'b1; end
      8'h42: begin lo = 8'h6B; letter = 1'b1; end
      8'h4B: begin lo = 8'h6C; letter = 1'b1; end
      8'h3A: begin lo = 8'h6D; letter = 1'b1; end
      8'h31: begin lo = 8'h6E; letter = 1'b1; end
      8'h44: begin lo = 8'h6F; letter = 1'b1; end
      8'h4D: begin lo = 8'h70; letter = 1'b1; end
      8'h15: begin lo = 8'h71; letter = 1'b1; end
      8'h2D: begin lo = 8'h72; letter = 1'b1; end
      8'h1B: begin lo = 8'h73; letter = 1'b1; end
      8'h2C: begin lo = 8'h74; letter = 1'b1; end
      8'h3C: begin lo = 8'h75; letter = 1'b1; end
      8'h2A: begin lo = 8'h76; letter = 1'b1; end
      8'h1D: begin lo = 8'h77; letter = 1'b1; end
      8'h22: begin lo = 8'h78; letter = 1'b1; end
      8'h35: begin lo = 8'h79; letter = 1'b1; end
      8'h1A: begin lo = 8'h7A; letter = 1'b1; end
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h54: begin lo = 8'h5B; hi = 8'h7B; end
      8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
      8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = 8'h2C; hi = 8'h3C; end
      8'h49: begin lo = 8'h2E; hi = 8'h3E; end
      8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      8'h0E: begin lo = 8'h60; hi = 8'h7E; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      default: begin lo = '0; hi = '0; end
    endcase
    if (letter) return (sh ^ cp) ? (lo - 8'h20) : lo;
    return sh ? hi : lo;
  endfunction

  // Three-flop synchronizers and falling-edge history; lines idle high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], data};
      clk_prev <= clk_sync[2];
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Frame next-state: advances on falling edges, timeout forces IDLE
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!bit_in) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Frame datapath: inactivity timer, bit shifter, byte hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_reg   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (state == S_IDLE || fall) timer <= '0;
      else                         timer <= timer + TW'(1);
      if (fall) begin
        case (state)
          S_IDLE: bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_STOP: begin
            byte_reg   <= shreg;
            byte_valid <= frame_ok;
          end
          default: ;
        endcase
      end
    end
  end

  // Byte decoder: prefix flags, modifiers, held-key tracking, registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      shift_on  <= 1'b0;
      caps_on   <= 1'b0;
      held      <= 1'b0;
      held_code <= '0;
      asc       <= '0;
    end else if (byte_valid) begin
      if (byte_reg == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_reg == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (!ext_flag) begin
          if (byte_reg == 8'h12 || byte_reg == 8'h59) begin
            shift_on <= !brk_flag;
          end else if (byte_reg == 8'h58) begin
            if (!brk_flag) caps_on <= !caps_on;
          end else if (brk_flag) begin
            if (held && held_code == byte_reg) begin
              held <= 1'b0;
              asc  <= '0;
            end
          end else if (map_code(byte_reg, shift_on, caps_on) != 8'h00) begin
            asc       <= map_code(byte_reg, shift_on, caps_on);
            held      <= 1'b1;
            held_code <= byte_reg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_ascii_fsm.sv
// Self-checking bench for ps2_ascii_fsm: directed scenarios followed by random
// key traffic, all compared against a table-driven keyboard model.
module tb_ps2_ascii_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       data = 1'b1;
  logic [7:0] asc;
  logic       en;

  int n_cmp = 0;
  int n_err = 0;

  ps2_ascii_fsm #(.TIMEOUT_CYCLES(50000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .data(data), .asc(asc), .en(en)
  );

  always #5 clk = ~clk;

  // US layout tables
  logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] digit_hi  [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
  logic [7:0] punct_sc  [11] = '{8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h0E};
  logic [7:0] punct_lo  [11] = '{8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F,8'h60};
  logic [7:0] punct_hi  [11] = '{8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F,8'h7E};
  logic [7:0] special_sc [4] = '{8'h29,8'h5A,8'h66,8'h0D};
  logic [7:0] special_a  [4] = '{8'h20,8'h0D,8'h08,8'h09};
  logic [7:0] unmapped   [4] = '{8'h01,8'h76,8'h05,8'h06};

  // Keyboard model state
  bit         m_shift, m_caps, m_ext, m_brk, m_held;
  logic [7:0] m_code, m_asc;
  logic [7:0] keys [$];

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) return sh ? digit_hi[i] : 8'(8'h30 + i);
    for (int i = 0; i < 11; i++)
      if (punct_sc[i] == c) return sh ? punct_hi[i] : punct_lo[i];
    for (int i = 0; i < 4; i++)
      if (special_sc[i] == c) return special_a[i];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_shift = 0; m_caps = 0; m_ext = 0; m_brk = 0; m_held = 0;
    m_code = '0; m_asc = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext) begin
        if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
        else if (b == 8'h58) begin
          if (!m_brk) m_caps = !m_caps;
        end else if (m_brk) begin
          if (m_held && m_code == b) begin m_held = 0; m_asc = 8'h00; end
        end else begin
          a = ref_ascii(b, m_shift, m_caps);
          if (a != 8'h00) begin m_asc = a; m_held = 1; m_code = b; end
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, ".asc"}, asc, m_asc);
    check({tag, ".en"}, {7'b0, en}, {7'b0, m_held});
  endtask

  // Drives the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop)
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      data = f[i];
      tick(3);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
    end
    data = 1'b1;
    tick(12);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    send_frame(b, 11, 0, 0);
    model_byte(b);
    check_out(tag);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    send_frame(b, 11, bad_par, bad_stop);
`ifndef PS2_PARITY_CHECK_EN
    model_byte(b);
`endif
    check_out(tag);
  endtask

  initial begin
    logic [7:0] k;
    int unsigned r;
    foreach (letter_sc[i])  keys.push_back(letter_sc[i]);
    foreach (digit_sc[i])   keys.push_back(digit_sc[i]);
    foreach (punct_sc[i])   keys.push_back(punct_sc[i]);
    foreach (special_sc[i]) keys.push_back(special_sc[i]);
    model_reset();

    tick(5);
    check_out("reset");
    rst = 1'b1;
    tick(5);

    send_byte(8'h1C, "a_make");
    send_byte(8'hF0, "a_pre");
    send_byte(8'h1C, "a_break");

    send_byte(8'h12, "shift_make");
    send_byte(8'h1C, "A_shift");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "A_break");
    send_byte(8'hF0, "p"); send_byte(8'h12, "shift_break");

    send_byte(8'h58, "caps_make");
    send_byte(8'hF0, "p"); send_byte(8'h58, "caps_break");
    send_byte(8'h1C, "A_caps");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "A_caps_break");
    send_byte(8'h12, "shift_caps");
    send_byte(8'h16, "bang");
    send_byte(8'h1C, "a_shift_caps");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "x");
    send_byte(8'hF0, "p"); send_byte(8'h16, "x");
    send_byte(8'hF0, "p"); send_byte(8'h12, "x");
    send_byte(8'h58, "caps_off");
    send_byte(8'hF0, "p"); send_byte(8'h58, "x");

    send_byte(8'h1C, "ovl_a");
    send_byte(8'h32, "ovl_b");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "ovl_a_break");
    send_byte(8'hF0, "p"); send_byte(8'h32, "ovl_b_break");

    send_byte(8'hE0, "ext_pre");
    send_byte(8'h75, "ext_key");

    send_frame(8'h00, 4, 0, 0);
    tick(60000);
    send_byte(8'h5A, "enter_after_timeout");
    send_byte(8'hF0, "p"); send_byte(8'h5A, "enter_break");

    send_bad(8'h1C, 1, 0, "bad_parity");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "bad_parity_cleanup");
    send_byte(8'h32, "b_make");
    send_byte(8'hF0, "prefix_kept");
    send_bad(8'h44, 0, 1, "bad_stop");
    send_byte(8'h32, "b_after_bad");
    send_byte(8'hF0, "p"); send_byte(8'h32, "x");

    send_byte(8'h12, "pre_rst_shift");
    send_byte(8'h1C, "pre_rst_A");
    send_frame(8'h32, 5, 0, 0);
    rst = 1'b0;
    model_reset();
    tick(2);
    check_out("mid_frame_reset");
    rst = 1'b1;
    tick(5);
    send_byte(8'h1C, "post_rst_a");
    send_byte(8'hF0, "p"); send_byte(8'h1C, "post_rst_break");

    for (int step = 0; step < 80; step++) begin
      r = $urandom_range(0, 9);
      k = keys[$urandom_range(0, keys.size() - 1)];
      case (r)
        0, 1, 2, 3: send_byte(k, "rnd_make");
        4, 5: begin
          if (m_held && $urandom_range(0, 1) == 1) k = m_code;
          send_byte(8'hF0, "rnd_pre");
          send_byte(k, "rnd_break");
        end
        6: begin
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0, "rnd_pre");
          send_byte(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, "rnd_shift");
        end
        7: begin
          if ($urandom_range(0, 3) == 0) send_byte(8'hF0, "rnd_pre");
          send_byte(8'h58, "rnd_caps");
        end
        8: begin
          send_byte(8'hE0, "rnd_ext");
          if ($urandom_range(0, 1) == 1) send_byte(8'hF0, "rnd_ext_pre");
          send_byte(k, "rnd_ext_key");
        end
        default: send_byte(unmapped[$urandom_range(0, 3)], "rnd_unmapped");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
